router_pkt_gen: RTL and testbench

Synthesizable packet source for the 1x3 router input port. Builds a packet from a command: a header byte of {len[5:0], dest[1:0]}, then len payload bytes from an incrementing or LFSR pattern, then an even-parity byte. Drives pkt_valid/data_out and obeys the router's busy back-pressure. Used in on-chip loopback/self-test traffic in front of the router.

---
 rtl/router_pkt_gen.sv | 137 +++++++++++++
 tb/tb_router_pkt_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_gen.sv
// Packet source for the 1x3 router input port: header {len,dest}, len payload bytes
// (incrementing or LFSR pattern), then an even-parity byte, honouring busy back-pressure.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a legal start command
// HEADER  | header byte {len,dest} on data_out, pkt_valid high
// PAYLOAD | pattern bytes on data_out, pkt_valid high
// PARITY  | parity byte on data_out, pkt_valid low
// GAP     | inter-packet idle gap, counts GAP_CYCLES cycles
module router_pkt_gen #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       dest,
    input  logic [5:0]       len,
    input  logic             mode,
    input  logic [7:0]       seed,
    input  logic             busy,
    output logic             pkt_valid,
    output logic [7:0]       data_out,
    output logic             gen_active,
    output logic             done,
    output logic             cmd_err,
    output logic [CNT_W-1:0] pkt_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HEADER  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] PARITY  = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [2:0]       state;
    logic [7:0]       parity;
    logic [7:0]       first_byte;
    logic [5:0]       remaining;
    logic             mode_r;
    logic [GAP_W-1:0] gap_cnt;

    function automatic logic [7:0] next_byte(input logic m, input logic [7:0] cur);
        if (m)
            return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
        else
            return cur + 8'd1;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pkt_valid  <= 1'b0;
            data_out   <= 8'h00;
            gen_active <= 1'b0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
            pkt_count  <= '0;
            parity     <= 8'h00;
            first_byte <= 8'h00;
            remaining  <= 6'd0;
            mode_r     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dest != 2'd3 && len != 6'd0) begin
                            // LFSR cannot leave the all-zero state, so a zero seed becomes 1
                            first_byte <= (mode && seed == 8'h00) ? 8'h01 : seed;
                            mode_r     <= mode;
                            remaining  <= len;
                            data_out   <= {len, dest};
                            parity     <= {len, dest};
                            pkt_valid  <= 1'b1;
                            gen_active <= 1'b1;
                            state      <= HEADER;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        data_out <= first_byte;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        if (remaining > 6'd1) begin
                            data_out  <= next_byte(mode_r, data_out);
                            parity    <= parity ^ data_out;
                            remaining <= remaining - 6'd1;
                        end else begin
                            data_out  <= parity ^ data_out;
                            pkt_valid <= 1'b0;
                            state     <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        data_out <= 8'h00;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end else begin
                            done       <= 1'b1;
                            gen_active <= 1'b0;
                            pkt_count  <= pkt_count + CNT_W'(1);
                            state      <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        done       <= 1'b1;
                        gen_active <= 1'b0;
                        pkt_count  <= pkt_count + CNT_W'(1);
                        state      <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen: directed test-plan packets plus randomized
// packets and back-pressure, checked against a byte-list model of each packet.
module tb_router_pkt_gen;

    localparam int GAP = 2;
    localparam int CW  = 16;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    dest = 2'd0;
    logic [5:0]    len = 6'd0;
    logic          mode = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic          busy = 1'b0;
    logic          pkt_valid;
    logic [7:0]    data_out;
    logic          gen_active;
    logic          done;
    logic          cmd_err;
    logic [CW-1:0] pkt_count;

    router_pkt_gen #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
        .clock(clock), .resetn(resetn), .start(start), .dest(dest), .len(len),
        .mode(mode), .seed(seed), .busy(busy), .pkt_valid(pkt_valid),
        .data_out(data_out), .gen_active(gen_active), .done(done),
        .cmd_err(cmd_err), .pkt_count(pkt_count)
    );

    always #5 clock = ~clock;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [7:0]    exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Whole packet as a list of bytes: header, payload pattern, XOR of everything before.
    function automatic void build(input logic [1:0] d, input logic [5:0] l,
                                  input logic m, input logic [7:0] s);
        logic [7:0] cur;
        logic [7:0] p;
        exp_q.delete();
        exp_q.push_back({l, d});
        cur = (m && s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(cur);
            if (m) cur = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
            else   cur = cur + 8'd1;
        end
        p = 8'h00;
        foreach (exp_q[i]) p ^= exp_q[i];
        exp_q.push_back(p);
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the done cycle.
    task automatic run_packet(input logic [1:0] d, input logic [5:0] l, input logic m,
                              input logic [7:0] s, input int hold_idx, input int hold_len,
                              input bit rnd, input bit hold_start);
        int idx;
        int held;
        int cyc;
        build(d, l, m, s);
        dest = d; len = l; mode = m; seed = s; start = 1'b1; busy = 1'b0;
        @(negedge clock);
        idx = 0; held = 0; cyc = 0;
        while (idx < exp_q.size()) begin
            check("data", 32'(data_out), 32'(exp_q[idx]));
            check("valid", 32'(pkt_valid), 32'(idx < exp_q.size() - 1));
            check("active", 32'(gen_active), 32'd1);
            check("done_mid", 32'(done), 32'd0);
            if (idx == hold_idx && held < hold_len) begin
                busy = 1'b1;
                held++;
            end else if (rnd) begin
                busy = ($urandom_range(0, 3) == 0);
            end else begin
                busy = 1'b0;
            end
            if (rnd) begin
                start = ($urandom_range(0, 1) == 1);
                dest  = 2'($urandom_range(0, 3));
                len   = 6'($urandom_range(0, 63));
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (!busy) idx++;
            cyc++;
            if (cyc > 600) begin
                check("stream_timeout", 32'd1, 32'd0);
                break;
            end
        end
        for (int g = 0; g < GAP; g++) begin
            check("gap_valid", 32'(pkt_valid), 32'd0);
            check("gap_data", 32'(data_out), 32'h00);
            check("gap_active", 32'(gen_active), 32'd1);
            check("gap_done", 32'(done), 32'd0);
            busy = ($urandom_range(0, 1) == 1);
            @(negedge clock);
        end
        exp_cnt++;
        check("done", 32'(done), 32'd1);
        check("end_active", 32'(gen_active), 32'd0);
        check("end_valid", 32'(pkt_valid), 32'd0);
        check("pkt_count", 32'(pkt_count), 32'(exp_cnt));
        busy = 1'b0;
        start = hold_start;
    endtask

    task automatic bad_cmd(input logic [1:0] d, input logic [5:0] l);
        dest = d; len = l; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("cmd_err", 32'(cmd_err), 32'd1);
        check("err_valid", 32'(pkt_valid), 32'd0);
        check("err_active", 32'(gen_active), 32'd0);
        check("err_count", 32'(pkt_count), 32'(exp_cnt));
        @(negedge clock);
        check("cmd_err_clr", 32'(cmd_err), 32'd0);
        check("err_valid2", 32'(pkt_valid), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_active", 32'(gen_active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(cmd_err), 32'd0);
        check("rst_count", 32'(pkt_count), 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        run_packet(2'd1, 6'd3, 1'b0, 8'h10, -1, 0, 1'b0, 1'b0);
        @(negedge clock); check("done_low", 32'(done), 32'd0);
        run_packet(2'd1, 6'd3, 1'b0, 8'h10, 2, 3, 1'b0, 1'b0);
        @(negedge clock);
        run_packet(2'd2, 6'd2, 1'b1, 8'h00, 3, 2, 1'b0, 1'b0);
        @(negedge clock);
        run_packet(2'd0, 6'd3, 1'b0, 8'hFE, -1, 0, 1'b0, 1'b0);
        @(negedge clock);
        run_packet(2'd2, 6'd1, 1'b1, 8'h80, -1, 0, 1'b0, 1'b0);
        @(negedge clock);
        run_packet(2'd0, 6'd63, 1'b1, 8'hA5, -1, 0, 1'b1, 1'b0);
        @(negedge clock);

        bad_cmd(2'd3, 6'd5);
        bad_cmd(2'd1, 6'd0);

        for (int k = 0; k < 20; k++) begin
            logic [5:0] l;
            l = ($urandom_range(0, 3) == 0) ? 6'd1 : 6'($urandom_range(1, 63));
            run_packet(2'($urandom_range(0, 2)), l, 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), -1, 0, 1'b1, 1'b0);
            @(negedge clock);
        end

        // Reset in the middle of a payload, then two back-to-back packets.
        dest = 2'd1; len = 6'd10; mode = 1'b0; seed = 8'h33; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("pre_rst_valid", 32'(pkt_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        exp_cnt = '0;
        check("mid_rst_valid", 32'(pkt_valid), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'h00);
        check("mid_rst_count", 32'(pkt_count), 32'd0);
        check("mid_rst_active", 32'(gen_active), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_valid", 32'(pkt_valid), 32'd0);
        run_packet(2'd2, 6'd4, 1'b0, 8'h40, -1, 0, 1'b0, 1'b1);
        run_packet(2'd0, 6'd5, 1'b1, 8'h17, -1, 0, 1'b0, 1'b0);
        @(negedge clock);
        check("final_count", 32'(pkt_count), 32'd2);
        check("final_valid", 32'(pkt_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
